dcache_wb_param: RTL and testbench

- Parametrised, direct-mapped, write-back, write-allocate data cache.
- Sits between the CPU load/store port and the block-wide data memory.
- Generalises the CPU's single BUSY_WAIT stall path: line count, block size, data width and address width are all set by parameters.
- Hits complete without a stall. Misses stall the CPU through a write-back/fetch state machine.

---
 rtl/dcache_wb_param.sv | 184 ++++++++++++++++++
 tb/tb_dcache_wb_param.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_param.sv
// dcache_wb_param: parametrised direct-mapped, write-back, write-allocate data cache.
// It sits between the CPU load/store port and a block-wide data memory.
// Hits complete in the same cycle. Misses stall the CPU through WRITEBACK/FETCH/UPDATE.
//
// Optional build macro: DCACHE_STATS_EN adds the saturating hit_count/miss_count outputs.
//
// Ports:
//   CLK, RESET             rising-edge clock; synchronous active-high reset
//   cpu_read, cpu_write    load/store request (both high = store)
//   cpu_addr               word address {tag, index, offset}
//   cpu_wdata / cpu_rdata  store data / load data (load data is combinational on a hit)
//   cpu_busywait           stall; the CPU holds its request while this is high
//   mem_read, mem_write    registered block fetch / write-back requests
//   mem_addr               block address {tag, index}
//   mem_wdata / mem_rdata  victim block / fetched block
//   mem_busywait           a transfer completes on the first low cycle after the request
//   hit_count, miss_count  (DCACHE_STATS_EN only) 16-bit saturating statistics
module dcache_wb_param #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned OFF_W   = 2
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              cpu_read,
    input  logic                              cpu_write,
    input  logic [ADDR_W-1:0]                 cpu_addr,
    input  logic [DATA_W-1:0]                 cpu_wdata,
    output logic [DATA_W-1:0]                 cpu_rdata,
    output logic                              cpu_busywait,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic [ADDR_W-OFF_W-1:0]           mem_addr,
    output logic [DATA_W*(2**OFF_W)-1:0]      mem_wdata,
    input  logic [DATA_W*(2**OFF_W)-1:0]      mem_rdata,
    input  logic                              mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]                       hit_count,
    output logic [15:0]                       miss_count
`endif
);

    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFF_W;
    localparam int unsigned WORDS   = 2 ** OFF_W;
    localparam int unsigned LINES   = 2 ** INDEX_W;
    localparam int unsigned BADDR_W = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_FETCH,
        S_UPDATE
    } state_t;

    typedef logic [WORDS-1:0][DATA_W-1:0] block_t;

    state_t                 state_q;
    block_t                 data_q [LINES];
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [LINES-1:0]       valid_q;
    logic [LINES-1:0]       dirty_q;
    logic [BADDR_W-1:0]     miss_blk_q;
    block_t                 fill_q;
    logic                   mem_read_q;
    logic                   mem_write_q;
    logic [BADDR_W-1:0]     mem_addr_q;
    block_t                 mem_wdata_q;

    logic [TAG_W-1:0]       cpu_tag;
    logic [INDEX_W-1:0]     cpu_idx;
    logic [OFF_W-1:0]       cpu_off;
    logic [INDEX_W-1:0]     miss_idx;
    logic [TAG_W-1:0]       miss_tag;
    logic                   access;
    logic                   hit;

    assign cpu_tag  = cpu_addr[ADDR_W-1:INDEX_W+OFF_W];
    assign cpu_idx  = cpu_addr[INDEX_W+OFF_W-1:OFF_W];
    assign cpu_off  = cpu_addr[OFF_W-1:0];
    assign miss_idx = miss_blk_q[INDEX_W-1:0];
    assign miss_tag = miss_blk_q[BADDR_W-1:INDEX_W];
    assign access   = cpu_read | cpu_write;
    assign hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    // Hit/stall response to the CPU is combinational so hits never stall
    always_comb begin
        cpu_busywait = (state_q != S_IDLE) || (access && !hit);
        cpu_rdata    = '0;
        if (state_q == S_IDLE && cpu_read && hit) begin
            cpu_rdata = data_q[cpu_idx][cpu_off];
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Miss FSM; memory requests are registered from the state being entered.
    // The miss block address is latched so a request dropped mid-miss still fills.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access && hit) begin
                        if (cpu_write) begin
                            data_q[cpu_idx][cpu_off] <= cpu_wdata;
                            dirty_q[cpu_idx]         <= 1'b1;
                        end
                    end else if (access) begin
                        miss_blk_q <= cpu_addr[ADDR_W-1:OFF_W];
                        if (valid_q[cpu_idx] && dirty_q[cpu_idx]) begin
                            state_q     <= S_WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[cpu_idx], cpu_idx};
                            mem_wdata_q <= data_q[cpu_idx];
                        end else begin
                            state_q    <= S_FETCH;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= cpu_addr[ADDR_W-1:OFF_W];
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (!mem_busywait) begin
                        state_q     <= S_FETCH;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= miss_blk_q;
                    end
                end
                S_FETCH: begin
                    if (!mem_busywait) begin
                        state_q    <= S_UPDATE;
                        mem_read_q <= 1'b0;
                        fill_q     <= mem_rdata;
                    end
                end
                S_UPDATE: begin
                    data_q[miss_idx]  <= fill_q;
                    tag_q[miss_idx]   <= miss_tag;
                    valid_q[miss_idx] <= 1'b1;
                    dirty_q[miss_idx] <= 1'b0;
                    state_q           <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;

    // Saturating counters: hits on every IDLE hit cycle, misses on every miss entry
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (state_q == S_IDLE && access) begin
            if (hit && hit_count_q != 16'hFFFF) begin
                hit_count_q <= hit_count_q + 16'd1;
            end
            if (!hit && miss_count_q != 16'hFFFF) begin
                miss_count_q <= miss_count_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_wb_param.sv
// tb_dcache_wb_param: self-checking bench for dcache_wb_param (default parameters).
// A flat word-array reference plus a per-line "which block lives here" table predicts
// load data and stall lengths; a latency-programmable block memory backs the DUT.
module tb_dcache_wb_param;

    logic        CLK;
    logic        RESET;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_busywait;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    dcache_wb_param dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_busywait (cpu_busywait),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_busywait (mem_busywait)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Backing block memory with programmable busy latency per transfer
    logic [31:0] bmem [64];
    int          mem_lat   = 0;
    int          busy_left = 0;

    assign mem_rdata    = bmem[mem_addr];
    assign mem_busywait = (mem_read || mem_write) && (busy_left != 0);

    always @(posedge CLK) begin
        if ((mem_read || mem_write) && busy_left != 0) busy_left <= busy_left - 1;
        else busy_left <= mem_lat;
        if (mem_write && !mem_busywait) bmem[mem_addr] = mem_wdata;
    end

    // Reference: CPU-visible word values and block residency per line
    logic [7:0] ref_word [256];
    int         line_blk [8];
    bit         line_dirty [8];

    function automatic void model_reset();
        for (int l = 0; l < 8; l++) begin
            line_blk[l]   = -1;
            line_dirty[l] = 1'b0;
        end
        for (int w = 0; w < 256; w++) begin
            logic [31:0] blk;
            blk = bmem[w / 4];
            ref_word[w] = blk[(w % 4) * 8 +: 8];
        end
    endfunction

    function automatic void model_access(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                                         input int lat, output int exp_stall, output logic [7:0] exp_rd);
        int idx;
        int blk;
        idx = int'(a[4:2]);
        blk = int'(a[7:2]);
        if (line_blk[idx] == blk) begin
            exp_stall = 0;
        end else begin
            exp_stall = line_dirty[idx] ? 4 + 2 * lat : 3 + lat;
            line_blk[idx]   = blk;
            line_dirty[idx] = 1'b0;
        end
        if (wr) begin
            ref_word[a]     = wd;
            line_dirty[idx] = 1'b1;
        end
        exp_rd = ref_word[a];
    endfunction

    // Drive one request (called just after a posedge) and hold it until the hit cycle
    task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] a,
                              input logic [7:0] wd, input string name);
        int         es;
        int         stalls;
        logic [7:0] er;
        bit         done;
        model_access(wr, a, wd, mem_lat, es, er);
        cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
        stalls = 0; done = 0;
        while (!done) begin
            @(negedge CLK);
            n_checks++;
            if (mem_read && mem_write) $display("FAIL %s_mem_excl: read=%0b write=%0b required not both", name, mem_read, mem_write);
            else n_pass++;
            if (!cpu_busywait) begin
                done = 1;
            end else begin
                stalls++;
                if (stalls > 100) begin
                    n_checks++;
                    $display("FAIL %s_timeout: busywait still high after %0d cycles", name, stalls);
                    done = 1;
                end
                @(posedge CLK); #1;
            end
        end
        n_checks++;
        if (stalls !== es) $display("FAIL %s_stalls: got %0d expected %0d (addr %0h)", name, stalls, es, a);
        else n_pass++;
        if (rd && !wr) begin
            n_checks++;
            if (cpu_rdata !== er) $display("FAIL %s_rdata: got %0h expected %0h (addr %0h)", name, cpu_rdata, er, a);
            else n_pass++;
        end
        @(posedge CLK); #1;
        cpu_read = 0; cpu_write = 0;
    endtask

    task automatic test_reset();
        RESET = 1;
        repeat (2) @(posedge CLK);
        #1 RESET = 0;
        model_reset();
        @(negedge CLK);
        n_checks++;
        if ({cpu_busywait, mem_read, mem_write} !== 3'b000)
            $display("FAIL reset_ctrl: got busy/rd/wr=%b expected 000", {cpu_busywait, mem_read, mem_write});
        else n_pass++;
        n_checks++;
        if (mem_addr !== 6'h00 || mem_wdata !== 32'h0 || cpu_rdata !== 8'h00)
            $display("FAIL reset_data: got addr=%0h wdata=%0h rdata=%0h expected 0", mem_addr, mem_wdata, cpu_rdata);
        else n_pass++;
`ifdef DCACHE_STATS_EN
        n_checks++;
        if (hit_count !== 16'd0 || miss_count !== 16'd0)
            $display("FAIL reset_stats: got hit=%0d miss=%0d expected 0 0", hit_count, miss_count);
        else n_pass++;
`endif
        @(posedge CLK); #1;
    endtask

    task automatic test_clean_miss();
        int         es;
        logic [7:0] er;
        model_access(1'b0, 8'h05, 8'h00, 0, es, er);
        cpu_read = 1; cpu_addr = 8'h05;
        @(negedge CLK);
        n_checks++;
        if (cpu_busywait !== 1'b1 || mem_read !== 1'b0)
            $display("FAIL clean_detect: got busy=%b rd=%b expected 1 0", cpu_busywait, mem_read);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 6'h01 || cpu_busywait !== 1'b1)
            $display("FAIL clean_fetch: got rd=%b wr=%b addr=%0h busy=%b expected 1 0 01 1", mem_read, mem_write, mem_addr, cpu_busywait);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (cpu_busywait !== 1'b1 || mem_read !== 1'b0)
            $display("FAIL clean_update: got busy=%b rd=%b expected 1 0", cpu_busywait, mem_read);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (cpu_busywait !== 1'b0 || cpu_rdata !== er)
            $display("FAIL clean_hit: got busy=%b rdata=%0h expected 0 %0h", cpu_busywait, cpu_rdata, er);
        else n_pass++;
        @(posedge CLK); #1;
        cpu_read = 0;
    endtask

    task automatic test_write_hit();
        cpu_access(1'b0, 1'b1, 8'h05, 8'hA5, "write_hit");
        cpu_access(1'b1, 1'b0, 8'h05, 8'h00, "read_hit");
    endtask

    task automatic test_dirty_miss();
        int          es;
        logic [7:0]  er;
        logic [31:0] wv;
        model_access(1'b0, 8'h25, 8'h00, 0, es, er);
        cpu_read = 1; cpu_addr = 8'h25;
        @(negedge CLK);
        n_checks++;
        if (cpu_busywait !== 1'b1 || mem_write !== 1'b0)
            $display("FAIL dirty_detect: got busy=%b wr=%b expected 1 0", cpu_busywait, mem_write);
        else n_pass++;
        @(negedge CLK);
        wv = mem_wdata;
        n_checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 6'h01 || wv[15:8] !== 8'hA5)
            $display("FAIL dirty_wb: got wr=%b rd=%b addr=%0h word1=%0h expected 1 0 01 a5", mem_write, mem_read, mem_addr, wv[15:8]);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 6'h09)
            $display("FAIL dirty_fetch: got rd=%b wr=%b addr=%0h expected 1 0 09", mem_read, mem_write, mem_addr);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (cpu_busywait !== 1'b1)
            $display("FAIL dirty_update: got busy=%b expected 1", cpu_busywait);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (cpu_busywait !== 1'b0 || cpu_rdata !== er)
            $display("FAIL dirty_hit: got busy=%b rdata=%0h expected 0 %0h", cpu_busywait, cpu_rdata, er);
        else n_pass++;
        wv = bmem[1];
        n_checks++;
        if (wv[15:8] !== 8'hA5)
            $display("FAIL dirty_mem_image: got %0h expected a5", wv[15:8]);
        else n_pass++;
        @(posedge CLK); #1;
        cpu_read = 0;
`ifdef DCACHE_STATS_EN
        @(negedge CLK);
        n_checks++;
        if (hit_count !== 16'd4 || miss_count !== 16'd2)
            $display("FAIL stats_counts: got hit=%0d miss=%0d expected 4 2", hit_count, miss_count);
        else n_pass++;
        @(posedge CLK); #1;
`endif
    endtask

    task automatic test_mem_stall();
        int         es;
        logic [7:0] er;
        mem_lat = 5;
        @(posedge CLK); #1;
        model_access(1'b0, 8'h48, 8'h00, 5, es, er);
        cpu_read = 1; cpu_addr = 8'h48;
        @(negedge CLK);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            n_checks++;
            if (mem_read !== 1'b1 || cpu_busywait !== 1'b1)
                $display("FAIL stall_fetch_%0d: got rd=%b busy=%b expected 1 1", k, mem_read, cpu_busywait);
            else n_pass++;
        end
        @(negedge CLK);
        n_checks++;
        if (mem_read !== 1'b1 || mem_busywait !== 1'b0)
            $display("FAIL stall_done: got rd=%b mbusy=%b expected 1 0", mem_read, mem_busywait);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (mem_read !== 1'b0 || cpu_busywait !== 1'b1)
            $display("FAIL stall_update: got rd=%b busy=%b expected 0 1", mem_read, cpu_busywait);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (cpu_busywait !== 1'b0 || cpu_rdata !== er)
            $display("FAIL stall_hit: got busy=%b rdata=%0h expected 0 %0h", cpu_busywait, cpu_rdata, er);
        else n_pass++;
        @(posedge CLK); #1;
        cpu_read = 0;
        mem_lat = 0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_wb();
        cpu_access(1'b0, 1'b1, 8'h0C, 8'h3C, "mkdirty");
        mem_lat = 10;
        @(posedge CLK); #1;
        cpu_read = 1; cpu_addr = 8'h2C;
        @(negedge CLK);
        @(negedge CLK);
        n_checks++;
        if (mem_write !== 1'b1 || mem_addr !== 6'h03)
            $display("FAIL rstwb_in_wb: got wr=%b addr=%0h expected 1 03", mem_write, mem_addr);
        else n_pass++;
        RESET = 1; cpu_read = 0;
        @(posedge CLK); #1;
        RESET = 0; mem_lat = 0;
        @(negedge CLK);
        n_checks++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0 || cpu_busywait !== 1'b0)
            $display("FAIL rstwb_idle: got wr=%b rd=%b busy=%b expected 0 0 0", mem_write, mem_read, cpu_busywait);
        else n_pass++;
        model_reset();
        @(posedge CLK); #1;
        cpu_access(1'b1, 1'b0, 8'h0C, 8'h00, "rstwb_remiss");
    endtask

    task automatic test_random();
        for (int i = 0; i < 250; i++) begin
            logic [7:0] a;
            logic [7:0] d;
            int         r;
            a = 8'($urandom_range(0, 127));
            d = 8'($urandom);
            r = $urandom_range(0, 3);
            cpu_access(r <= 1, r >= 2, a, d, "rand");
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        RESET = 1; cpu_read = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
        for (int b = 0; b < 64; b++) bmem[b] = $urandom;
        test_reset();
        test_clean_miss();
        test_write_hit();
        test_dirty_miss();
        test_mem_stall();
        test_reset_mid_wb();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
